usb_tx_encoder: RTL and testbench

//  Transmit end of the full-speed USB bit-level link: the counterpart of the receive

---
 rtl/usb_tx_pkg.sv | 30 +++
 rtl/tx_bit_timer.sv | 31 +++
 rtl/usb_tx_encoder.sv | 222 ++++++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the full-speed USB transmit encoder.
//   tx_state_t  : transmit FSM states
//   SYNC_BYTE   : SYNC pattern, sent LSB-first
//   STUFF_LIMIT : consecutive ones that force a stuff bit
//   LINE_*      : {d_plus, d_minus} line states
//   nrzi_next   : next line state for a bit under NRZI
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // A 0 bit toggles J<->K, a 1 bit holds the line.
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
    return bit_val ? line : ~line;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-time counter for the USB transmit encoder.
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : hold the count at 0 (idle)
//   wrap       : high for one clk in the last cycle of each bit time
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic wrap
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wrap = !clear && (cnt_q == LAST);

endmodule

// File: rtl/usb_tx_encoder.sv
// Full-speed USB bit-level transmitter: SYNC, LSB-first data with bit stuffing,
// NRZI line coding and EOP, driving D+/D- straight from registers.
//   clk, n_rst         : clock, asynchronous active-low reset
//   tx_start           : begin a packet (only honoured when idle)
//   tx_data/valid/last : byte stream in; accepted when tx_valid && tx_ready
//   tx_ready           : one-byte buffer can take a byte
//   d_plus, d_minus    : USB line pair
//   tx_busy            : packet in progress, SYNC through EOP
//   tx_done            : one-clk pulse after the EOP J bit
//   tx_error           : one-clk pulse when a byte boundary finds no byte
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  tx_state_t   state_q, state_d;
  logic [1:0]  line_q, line_d;
  logic [7:0]  sh_q, sh_d;          // sh_q[0] is the bit currently on the line
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  ones_q, ones_d;      // consecutive ones among completed bits
  logic        last_q, last_d;      // byte in the shift reg ends the packet
  logic [7:0]  buf_q, buf_d;
  logic        buf_last_q, buf_last_d;
  logic        buf_full_q, buf_full_d;
  logic        last_acc_q, last_acc_d;
  logic        stuff_bnd_q, stuff_bnd_d; // stuff bit sits on a byte boundary
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        bit_wrap;
  logic        accept;
  logic        boundary;
  logic [2:0]  ones_next;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (state_q == IDLE),
    .wrap  (bit_wrap)
  );

  assign accept    = tx_valid && ready_q;
  assign ones_next = sh_q[0] ? (ones_q + 3'd1) : 3'd0;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    last_d      = last_q;
    buf_d       = buf_q;
    buf_last_d  = buf_last_q;
    buf_full_d  = buf_full_q;
    last_acc_d  = last_acc_q;
    stuff_bnd_d = stuff_bnd_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    boundary    = 1'b0;

    // Accept never coincides with a buffer load: one needs empty, the other full.
    if (accept) begin
      buf_d      = tx_data;
      buf_last_d = tx_last;
      buf_full_d = 1'b1;
      last_acc_d = tx_last;
    end

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d     = SYNC;
          sh_d        = SYNC_BYTE;
          bit_cnt_d   = 3'd0;
          ones_d      = 3'd0;
          last_d      = 1'b0;
          buf_full_d  = 1'b0;
          last_acc_d  = 1'b0;
          stuff_bnd_d = 1'b0;
          line_d      = nrzi_next(line_q, SYNC_BYTE[0]);
        end
      end
      SYNC, DATA: begin
        if (bit_wrap) begin
          if (ones_next == STUFF_LIMIT) begin
            // Advance past the finished bit now; STUFF resumes from sh_q[0].
            state_d     = STUFF;
            line_d      = ~line_q;
            ones_d      = 3'd0;
            stuff_bnd_d = (bit_cnt_q == 3'd7);
            sh_d        = sh_q >> 1;
            bit_cnt_d   = bit_cnt_q + 3'd1;
          end else if (bit_cnt_q == 3'd7) begin
            ones_d   = ones_next;
            boundary = 1'b1;
          end else begin
            ones_d    = ones_next;
            sh_d      = sh_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            line_d    = nrzi_next(line_q, sh_q[1]);
          end
        end
      end
      STUFF: begin
        if (bit_wrap) begin
          if (stuff_bnd_q) begin
            boundary = 1'b1;
          end else begin
            state_d = DATA;
            line_d  = nrzi_next(line_q, sh_q[0]);
          end
        end
      end
      EOP_SE0: begin
        if (bit_wrap) begin
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d = 3'd1;
          end else begin
            state_d = EOP_J;
            line_d  = LINE_J;
          end
        end
      end
      EOP_J: begin
        if (bit_wrap) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = LINE_J;
      end
    endcase

    if (boundary) begin
      if (last_q) begin
        state_d   = EOP_SE0;
        line_d    = LINE_SE0;
        bit_cnt_d = 3'd0;
      end else if (buf_full_q) begin
        state_d    = DATA;
        sh_d       = buf_q;
        last_d     = buf_last_q;
        buf_full_d = 1'b0;
        bit_cnt_d  = 3'd0;
        line_d     = nrzi_next(line_q, buf_q[0]);
      end else begin
        err_d     = 1'b1;
        state_d   = EOP_SE0;
        line_d    = LINE_SE0;
        bit_cnt_d = 3'd0;
      end
    end

    ready_d = ((state_d == SYNC) || (state_d == DATA) || (state_d == STUFF))
              && !buf_full_d && !last_acc_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      line_q      <= LINE_J;
      bit_cnt_q   <= 3'd0;
      ones_q      <= 3'd0;
      last_q      <= 1'b0;
      buf_last_q  <= 1'b0;
      buf_full_q  <= 1'b0;
      last_acc_q  <= 1'b0;
      stuff_bnd_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      last_q      <= last_d;
      buf_last_q  <= buf_last_d;
      buf_full_q  <= buf_full_d;
      last_acc_q  <= last_acc_d;
      stuff_bnd_q <= stuff_bnd_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Pure data registers: only read when the control state says they are valid.
  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    buf_q <= buf_d;
  end

  assign d_plus   = line_q[1];
  assign d_minus  = line_q[0];
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_error = err_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
module tb_usb_tx_encoder;

  localparam int         CPB = 8;
  localparam logic [1:0] LJ  = 2'b10;
  localparam logic [1:0] LK  = 2'b01;
  localparam logic [1:0] LSE = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_error;

  int errors = 0;
  int checks = 0;

  logic [7:0] pkt [$];
  bit         trunc = 1'b0;
  logic [1:0] exp_line [$];
  int         exp_se0_idx;

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit list = 7 zeros, a one, then every byte LSB-first; a 0 flips
  // the line, six ones in a row add a flipped stuff bit; then SE0, SE0, J.
  task automatic build_model();
    logic       bits [$];
    logic [7:0] b;
    logic [1:0] ln;
    int         ones;
    exp_line.delete();
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    foreach (pkt[i]) begin
      b = pkt[i];
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
    end
    ln   = LJ;
    ones = 0;
    foreach (bits[i]) begin
      if (bits[i]) ones++;
      else begin
        ln   = (ln == LJ) ? LK : LJ;
        ones = 0;
      end
      exp_line.push_back(ln);
      if (ones == 6) begin
        ln   = (ln == LJ) ? LK : LJ;
        ones = 0;
        exp_line.push_back(ln);
      end
    end
    exp_se0_idx = exp_line.size();
    exp_line.push_back(LSE);
    exp_line.push_back(LSE);
    exp_line.push_back(LJ);
  endtask

  task automatic run_packet(input string name);
    int tmo;
    build_model();
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = pkt[0];
    tx_valid = 1'b1;
    tx_last  = !trunc && (pkt.size() == 1);
    @(negedge clk);
    tx_start = 1'b0;
    check({name, ":busy_start"}, 32'(tx_busy), 32'd1);
    fork
      begin
        for (int k = 0; k < exp_line.size(); k++) begin
          for (int c = 0; c < CPB; c++) begin
            check($sformatf("%s:line[%0d]", name, k), 32'({d_plus, d_minus}), 32'(exp_line[k]));
            check($sformatf("%s:err[%0d]", name, k), 32'(tx_error),
                  32'(trunc && (k == exp_se0_idx) && (c == 0)));
            check($sformatf("%s:done_early[%0d]", name, k), 32'(tx_done), 32'd0);
            @(negedge clk);
          end
        end
        check({name, ":done"}, 32'(tx_done), 32'd1);
        check({name, ":busy_end"}, 32'(tx_busy), 32'd0);
        check({name, ":ready_end"}, 32'(tx_ready), 32'd0);
        check({name, ":line_end"}, 32'({d_plus, d_minus}), 32'(LJ));
        @(negedge clk);
        check({name, ":done_pulse"}, 32'(tx_done), 32'd0);
      end
      begin
        for (int i = 0; i < pkt.size(); i++) begin
          tx_data  = pkt[i];
          tx_valid = 1'b1;
          tx_last  = !trunc && (i == pkt.size() - 1);
          tmo = 0;
          while (tx_ready !== 1'b1 && tmo < 1000) begin
            @(negedge clk);
            tmo++;
          end
          check($sformatf("%s:accept_wait[%0d]", name, i), 32'(tmo < 1000), 32'd1);
          @(posedge clk);
          @(negedge clk);
          check($sformatf("%s:ready_drop[%0d]", name, i), 32'(tx_ready), 32'd0);
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        // A start request mid-packet must not disturb the line sequence.
        if (tx_busy) begin
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:d_plus", 32'(d_plus), 32'd1);
    check("rst:d_minus", 32'(d_minus), 32'd0);
    check("rst:ready", 32'(tx_ready), 32'd0);
    check("rst:busy", 32'(tx_busy), 32'd0);
    check("rst:done", 32'(tx_done), 32'd0);
    check("rst:error", 32'(tx_error), 32'd0);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle:line", 32'({d_plus, d_minus}), 32'(LJ));

    trunc = 1'b0;
    pkt = {8'h00};        run_packet("byte00");
    pkt = {8'hFF};        run_packet("byteFF");
    pkt = {8'hA5, 8'h3C}; run_packet("a5_3c");
    pkt = {8'hFC, 8'h01}; run_packet("stuff_bnd");
    pkt = {8'hFC};        run_packet("stuff_eop");
    trunc = 1'b1;
    pkt = {8'h01};        run_packet("underrun");
    trunc = 1'b0;

    // tx_valid outside a packet is ignored.
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid:ready", 32'(tx_ready), 32'd0);
    check("idle_valid:busy", 32'(tx_busy), 32'd0);
    check("idle_valid:line", 32'({d_plus, d_minus}), 32'(LJ));
    tx_valid = 1'b0;

    // Reset in the middle of the data byte.
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    tx_last  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (95) @(negedge clk);
    check("mid_rst:busy_before", 32'(tx_busy), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst:line", 32'({d_plus, d_minus}), 32'(LJ));
    check("mid_rst:busy", 32'(tx_busy), 32'd0);
    check("mid_rst:ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    pkt = {8'hC3, 8'h7E}; run_packet("after_rst");

    for (int r = 0; r < 6; r++) begin
      int n;
      pkt.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      trunc = ($urandom_range(0, 3) == 0);
      run_packet($sformatf("rand%0d", r));
    end
    trunc = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
